// File: rtl/alu_seq_acc.sv
// alu_seq_acc -- registered ALU with a valid/ready request handshake, result
// flags, an accumulator that can stand in for operand A, and a multi-cycle
// shift-add multiplier.
//
// Optional build macro: ALU_SAT_EN
//   defined   : ADD clamps to all-ones on carry-out and SUB clamps to zero on
//               borrow. carry still reports the raw carry/borrow.
//   undefined : ADD/SUB wrap modulo 2^WIDTH.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CNT_W  width of the multiply iteration counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   high when a request can be accepted this cycle
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 MUL
//   use_acc    take operand A from the accumulator instead of port A
//   A, B       operands (B unused by SHL1/SHR1)
//   Output     registered result
//   carry      registered carry/borrow/overflow flag
//   zero       registered, high when Output == 0
//   out_valid  one-cycle pulse marking a fresh Output/carry/zero
//   acc        accumulator (reloaded with every completed result)
module alu_seq_acc #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             carry,
  output logic             zero,
  output logic             out_valid,
  output logic [WIDTH-1:0] acc
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               carry_reg;
  logic               zero_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   acc_reg;

  logic               accept;
  logic               mul_last;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_step;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid && in_ready;
  assign op_a      = use_acc ? acc_reg : A;

  assign Output    = out_reg;
  assign carry     = carry_reg;
  assign zero      = zero_reg;
  assign out_valid = out_valid_reg;
  assign acc       = acc_reg;

  // Zero-extended add/subtract; the extra MSB is the carry-out, or the
  // borrow for subtraction (the difference wraps negative).
  assign add_ext = {1'b0, op_a} + {1'b0, B};
  assign sub_ext = {1'b0, op_a} - {1'b0, B};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_carry = add_ext[WIDTH];
`ifdef ALU_SAT_EN
        alu_res = add_ext[WIDTH] ? {WIDTH{1'b1}} : add_ext[WIDTH-1:0];
`else
        alu_res = add_ext[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        alu_carry = sub_ext[WIDTH];
`ifdef ALU_SAT_EN
        alu_res = sub_ext[WIDTH] ? {WIDTH{1'b0}} : sub_ext[WIDTH-1:0];
`else
        alu_res = sub_ext[WIDTH-1:0];
`endif
      end
      OP_AND: alu_res = op_a & B;
      OP_OR:  alu_res = op_a | B;
      OP_XOR: alu_res = op_a ^ B;
      OP_SHL: begin
        alu_res   = {op_a[WIDTH-2:0], 1'b0};
        alu_carry = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, op_a[WIDTH-1:1]};
        alu_carry = op_a[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Shift-add multiply: the low half starts as the multiplier. Each step
  // adds the multiplicand into the high half when the current multiplier
  // LSB is set, then shifts the whole register right, keeping the adder's
  // carry-out as the new MSB. After WIDTH steps it holds the full product.
  assign step_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                     (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign prod_step = {step_sum, prod_reg[WIDTH-1:1]};
  assign mul_last  = (state_reg == MUL) && (cnt_reg == CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && (op == OP_MUL)) state_next = MUL;
      MUL:     if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      prod_reg      <= '0;
      out_reg       <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mcand_reg <= op_a;
          prod_reg  <= {{WIDTH{1'b0}}, B};
          cnt_reg   <= CNT_W'(WIDTH);
        end else begin
          out_reg       <= alu_res;
          carry_reg     <= alu_carry;
          zero_reg      <= (alu_res == '0);
          out_valid_reg <= 1'b1;
          acc_reg       <= alu_res;
        end
      end else if (state_reg == MUL) begin
        prod_reg <= prod_step;
        cnt_reg  <= cnt_reg - CNT_W'(1);
        if (mul_last) begin
          out_reg       <= prod_step[WIDTH-1:0];
          carry_reg     <= |prod_step[2*WIDTH-1:WIDTH];
          zero_reg      <= (prod_step[WIDTH-1:0] == '0);
          out_valid_reg <= 1'b1;
          acc_reg       <= prod_step[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_acc.sv
// tb_alu_seq_acc -- scoreboard bench for alu_seq_acc (WIDTH=4).
// Issued requests push their expected result into a queue computed by a
// plain-arithmetic reference model; an independent monitor pops and compares
// on every out_valid cycle.
module tb_alu_seq_acc;

  localparam int WIDTH = 4;
  localparam int MAXV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic             use_acc = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [WIDTH-1:0] Output;
  logic             carry;
  logic             zero;
  logic             out_valid;
  logic [WIDTH-1:0] acc;

  alu_seq_acc #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_acc(use_acc), .A(A), .B(B),
    .Output(Output), .carry(carry), .zero(zero),
    .out_valid(out_valid), .acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic [WIDTH-1:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   model_acc = 0;
  bit   prev_single = 1'b0;
  int   txn = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference model: straight integer arithmetic on unsigned operands.
  function automatic void model(input int o, input int a, input int b,
                                output int r, output int c);
    int s;
    r = 0; c = 0;
    case (o)
      0: begin
        s = a + b; c = (s >= MAXV) ? 1 : 0; r = s % MAXV;
`ifdef ALU_SAT_EN
        if (c == 1) r = MAXV - 1;
`endif
      end
      1: begin
        c = (a < b) ? 1 : 0; r = (a + MAXV - b) % MAXV;
`ifdef ALU_SAT_EN
        if (c == 1) r = 0;
`endif
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % MAXV; c = (a >= MAXV / 2) ? 1 : 0; end
      6: begin r = a / 2; c = a % 2; end
      default: begin s = a * b; r = s % MAXV; c = (s >= MAXV) ? 1 : 0; end
    endcase
  endfunction

  // Monitor: every out_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out_valid: got Output=%0d with nothing outstanding", Output);
      end else begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: Output=%0d carry=%0d zero=%0d acc=%0d (expected %0d/%0d/%0d/%0d)",
                 txn, Output, carry, zero, acc, e.res, e.c, e.z, e.acc);
        check("result", int'(Output), int'(e.res));
        check("carry", int'(carry), int'(e.c));
        check("zero", int'(zero), int'(e.z));
        check("acc", int'(acc), int'(e.acc));
      end
    end
  end

  task automatic issue(input int o, input bit ua, input int a, input int b);
    int av, r, c;
    exp_t e;
    @(negedge clk);
    check("out_valid_timing", int'(out_valid), int'(prev_single));
    op = 3'(o); use_acc = ua; A = WIDTH'(a); B = WIDTH'(b); in_valid = 1'b1;
    check("in_ready_idle", int'(in_ready), 1);
    av = ua ? model_acc : a;
    model(o, av, b, r, c);
    model_acc = r;
    e.res = WIDTH'(r); e.c = c[0]; e.z = (r == 0); e.acc = WIDTH'(r);
    exp_q.push_back(e);
    prev_single = (o != 7);
  endtask

  // Follows a MUL issue: in_ready low for WIDTH cycles while junk requests
  // are offered, then in_ready and out_valid high together.
  task automatic mul_busy();
    for (int i = 1; i <= WIDTH + 1; i++) begin
      @(negedge clk);
      if (i <= WIDTH) begin
        check("mul_in_ready_low", int'(in_ready), 0);
        check("mul_no_out_valid", int'(out_valid), 0);
        op = 3'd0; use_acc = 1'b0;
        A = WIDTH'($urandom_range(MAXV - 1)); B = WIDTH'($urandom_range(MAXV - 1));
        in_valid = 1'b1;
      end else begin
        check("mul_done_in_ready", int'(in_ready), 1);
        check("mul_done_out_valid", int'(out_valid), 1);
        in_valid = 1'b0;
      end
    end
    prev_single = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("out_valid_timing", int'(out_valid), int'(prev_single));
      prev_single = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int o;
    // Reset for two cycles, then check reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_Output", int'(Output), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_zero", int'(zero), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_in_ready", int'(in_ready), 1);

    issue(0, 0, 5, 9);
    idle(1);
    check("first_add_Output", int'(Output), 14);
    check("first_add_acc", int'(acc), 14);

    issue(0, 0, 6, 15);
    issue(1, 0, 4, 11);
    idle(1);

    issue(7, 0, 3, 5);  mul_busy();
    issue(7, 0, 8, 8);  mul_busy();

    // Back-to-back: XOR, SHL1 from acc, SHR1.
    issue(4, 0, 11, 10);
    issue(5, 1, 0, 0);
    issue(6, 0, 3, 0);
    idle(1);

    // Accumulator chain.
    issue(0, 0, 3, 1);
    issue(0, 1, 0, 12);
    idle(1);

    // Randomized mix, including MUL and use_acc.
    for (int i = 0; i < 60; i++) begin
      o = $urandom_range(7);
      issue(o, 1'($urandom_range(1)), $urandom_range(MAXV - 1), $urandom_range(MAXV - 1));
      if (o == 7) mul_busy();
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(1);

    // Reset two cycles into a MUL: the product is discarded.
    issue(7, 0, 7, 9);
    @(negedge clk); in_valid = 1'b0;
    check("pre_rst_busy", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_acc = 0;
    prev_single = 1'b0;
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_acc", int'(acc), 0);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_Output", int'(Output), 0);
    idle(WIDTH + 2);
    issue(0, 0, 2, 3);
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
